// File: rtl/biu_ahb_arbiter_if.sv
// rtl/biu_ahb_arbiter_if.sv - requester-side and AHB-side signal bundle for the BIU master-port arbiter
// The slave modport is the arbiter's view; the master modport is the requester/bus-model view.
interface biu_ahb_arbiter_if #(
   parameter int NM = 3,
   parameter int AW = 64,
   parameter int DW = 64
);
   logic [NM-1:0]    bus_req;
   logic [NM-1:0]    bus_ack;
   logic [NM*AW-1:0] m_haddr;
   logic [NM-1:0]    m_hwrite;
   logic [NM*4-1:0]  m_hsize;
   logic [NM*3-1:0]  m_hburst;
   logic [NM*4-1:0]  m_hprot;
   logic [NM*2-1:0]  m_htrans;
   logic [NM-1:0]    m_hmastlock;
   logic [NM*DW-1:0] m_hwdata;
   logic [AW-1:0]    haddr;
   logic             hwrite;
   logic [3:0]       hsize;
   logic [2:0]       hburst;
   logic [3:0]       hprot;
   logic [1:0]       htrans;
   logic             hmastlock;
   logic [DW-1:0]    hwdata;
   logic             hready;
   logic             hresp;
   logic [1:0]       owner;

   modport slave (
      input  bus_req, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot,
             m_htrans, m_hmastlock, m_hwdata, hready, hresp,
      output bus_ack, haddr, hwrite, hsize, hburst, hprot, htrans,
             hmastlock, hwdata, owner
   );

   modport master (
      output bus_req, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot,
             m_htrans, m_hmastlock, m_hwdata, hready, hresp,
      input  bus_ack, haddr, hwrite, hsize, hburst, hprot, htrans,
             hmastlock, hwdata, owner
   );
endinterface

// File: rtl/biu_ahb_arbiter.sv
// rtl/biu_ahb_arbiter.sv - shares the BIU AHB master port between TLB (0), D-cache (1) and I-cache (2)
// Define BIU_ARB_RR_EN to alternate requesters 1 and 2 on ties; requester 0 always keeps top priority.
module biu_ahb_arbiter #(
   parameter int NM = 3,
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic             clk,
   input  logic             rst,
   biu_ahb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_OWN      = 2'd1,
      ARB_HANDOVER = 2'd2
   } arb_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   arb_state_t    r_state;
   logic [NM-1:0] r_bus_ack;
   logic [1:0]    r_owner;
   logic [1:0]    r_data_owner;
   logic          r_data_owner_vld;
`ifdef BIU_ARB_RR_EN
   // 1 when requester 2 held the last grant among requesters 1 and 2
   logic          r_last_grant;
`endif

   logic [AW-1:0] w_haddr     [NM];
   logic [3:0]    w_hsize     [NM];
   logic [2:0]    w_hburst    [NM];
   logic [3:0]    w_hprot     [NM];
   logic [1:0]    w_htrans    [NM];
   logic [DW-1:0] w_hwdata    [NM];

   genvar gi;
   generate
      for (gi = 0; gi < NM; gi++) begin : g_unpack
         assign w_haddr[gi]  = bus.m_haddr[gi*AW +: AW];
         assign w_hsize[gi]  = bus.m_hsize[gi*4 +: 4];
         assign w_hburst[gi] = bus.m_hburst[gi*3 +: 3];
         assign w_hprot[gi]  = bus.m_hprot[gi*4 +: 4];
         assign w_htrans[gi] = bus.m_htrans[gi*2 +: 2];
         assign w_hwdata[gi] = bus.m_hwdata[gi*DW +: DW];
      end
   endgenerate

   logic [1:0]    w_winner;
   logic [NM-1:0] w_winner_oh;
   logic          w_own;
   logic          w_release;
   logic          w_unused_hresp;

   // Error responses are handled by the requester; release follows the normal rule.
   assign w_unused_hresp = bus.hresp;

   always_comb begin
      w_winner = 2'd0;
      if (bus.bus_req[0]) begin
         w_winner = 2'd0;
`ifdef BIU_ARB_RR_EN
      end else if (bus.bus_req[1] && bus.bus_req[2]) begin
         w_winner = r_last_grant ? 2'd1 : 2'd2;
`endif
      end else if (bus.bus_req[1]) begin
         w_winner = 2'd1;
      end else if (bus.bus_req[2]) begin
         w_winner = 2'd2;
      end
   end

   assign w_winner_oh = NM'(1) << w_winner;
   assign w_own       = (r_state == ARB_OWN);

   // Only an idle, non-requesting owner on a ready bus may give up the port.
   assign w_release = w_own
                    && !bus.bus_req[r_owner]
                    && (w_htrans[r_owner] == HTRANS_IDLE)
                    && bus.hready;

   assign bus.haddr     = w_own ? w_haddr[r_owner]         : '0;
   assign bus.hwrite    = w_own ? bus.m_hwrite[r_owner]    : 1'b0;
   assign bus.hsize     = w_own ? w_hsize[r_owner]         : 4'd0;
   assign bus.hburst    = w_own ? w_hburst[r_owner]        : 3'd0;
   assign bus.hprot     = w_own ? w_hprot[r_owner]         : 4'd0;
   assign bus.htrans    = w_own ? w_htrans[r_owner]        : HTRANS_IDLE;
   assign bus.hmastlock = w_own ? bus.m_hmastlock[r_owner] : 1'b0;
   assign bus.hwdata    = r_data_owner_vld ? w_hwdata[r_data_owner] : '0;
   assign bus.bus_ack   = r_bus_ack;
   assign bus.owner     = r_owner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= ARB_IDLE;
         r_bus_ack        <= '0;
         r_owner          <= 2'd0;
         r_data_owner     <= 2'd0;
         r_data_owner_vld <= 1'b0;
`ifdef BIU_ARB_RR_EN
         r_last_grant     <= 1'b1;
`endif
      end else begin
         // The data phase follows whoever owned the address phase when it was accepted.
         if (bus.hready) begin
            if (bus.htrans == HTRANS_NONSEQ) begin
               r_data_owner     <= r_owner;
               r_data_owner_vld <= 1'b1;
            end else if (bus.htrans == HTRANS_IDLE) begin
               r_data_owner_vld <= 1'b0;
            end
         end

         case (r_state)
            ARB_IDLE: begin
               if ((|bus.bus_req) && bus.hready) begin
                  r_owner   <= w_winner;
                  r_bus_ack <= w_winner_oh;
                  r_state   <= ARB_OWN;
`ifdef BIU_ARB_RR_EN
                  if (w_winner != 2'd0) begin
                     r_last_grant <= (w_winner == 2'd2);
                  end
`endif
               end
            end
            ARB_OWN: begin
               if (w_release) begin
                  r_bus_ack <= '0;
                  r_state   <= ARB_HANDOVER;
               end
            end
            ARB_HANDOVER: begin
               r_state <= ARB_IDLE;
            end
            default: begin
               r_bus_ack <= '0;
               r_state   <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_biu_ahb_arbiter.sv
// tb/tb_biu_ahb_arbiter.sv - scoreboard bench for biu_ahb_arbiter (build with or without BIU_ARB_RR_EN)
module tb_biu_ahb_arbiter;
   localparam int NM = 3;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [1:0] I = 2'b00;
   localparam logic [1:0] N = 2'b10;
`ifdef BIU_ARB_RR_EN
   localparam logic [2:0] TIE2_ACK = 3'b100;
`else
   localparam logic [2:0] TIE2_ACK = 3'b010;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   biu_ahb_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

   biu_ahb_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] req;
      logic [1:0] ht2;
      logic [1:0] ht1;
      logic [1:0] ht0;
      logic       rdy;
      logic [2:0] ack;
      logic [1:0] htr;
      logic       dv;
      logic [1:0] dsel;
   } row_t;

   typedef struct packed {
      logic [2:0]    ack;
      logic [1:0]    owner;
      logic [1:0]    htr;
      logic          hwrite;
      logic [AW-1:0] haddr;
      logic [DW-1:0] hwdata;
   } exp_t;

   logic [AW-1:0] tb_addr  [3];
   logic [DW-1:0] tb_wdata [3];
   logic [2:0]    tb_write = 3'b001;
   exp_t          sb[$];
   int            n_cmp  = 0;
   int            n_fail = 0;

   function automatic row_t mk(input logic [2:0] req, input logic [1:0] ht0,
                               input logic [1:0] ht1, input logic [1:0] ht2,
                               input logic rdy, input logic [2:0] ack,
                               input logic [1:0] htr, input logic dv,
                               input logic [1:0] dsel);
      row_t r;
      r.req = req; r.ht0 = ht0; r.ht1 = ht1; r.ht2 = ht2; r.rdy = rdy;
      r.ack = ack; r.htr = htr; r.dv = dv; r.dsel = dsel;
      return r;
   endfunction

   function automatic logic [1:0] ack_idx(input logic [2:0] a);
      if (a[2]) return 2'd2;
      if (a[1]) return 2'd1;
      return 2'd0;
   endfunction

   function automatic exp_t expect_of(input row_t r);
      exp_t e;
      e.ack    = r.ack;
      e.owner  = ack_idx(r.ack);
      e.htr    = r.htr;
      e.hwrite = (r.ack != 3'b000) ? tb_write[e.owner] : 1'b0;
      e.haddr  = (r.ack != 3'b000) ? tb_addr[e.owner] : '0;
      e.hwdata = r.dv ? tb_wdata[r.dsel] : '0;
      return e;
   endfunction

   task automatic apply(input row_t r);
      bus.bus_req  = r.req;
      bus.m_htrans = {r.ht2, r.ht1, r.ht0};
      bus.hready   = r.rdy;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      apply(mk(3'b111, N, N, N, 1'b1, 3'b000, I, 1'b0, 2'd0));
      sb.push_back(expect_of(mk(3'b111, N, N, N, 1'b1, 3'b000, I, 1'b0, 2'd0)));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 5;
      if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL reset bus_ack got %b want %b", bus.bus_ack, e.ack); end
      if (bus.owner !== e.owner)   begin n_fail++; $display("FAIL reset owner got %0d want %0d", bus.owner, e.owner); end
      if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL reset htrans got %b want %b", bus.htrans, e.htr); end
      if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL reset haddr got %h want %h", bus.haddr, e.haddr); end
      if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL reset hwdata got %h want %h", bus.hwdata, e.hwdata); end
      apply(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rst = 1'b0;
   endtask

   task automatic test_grant_latency();
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(3'b100, I, I, I, 1'b1, 3'b100, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b100, I, I, N, 1'b1, 3'b100, N, 1'b1, 2'd2));
      rows.push_back(mk(3'b100, I, I, I, 1'b1, 3'b100, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(expect_of(rows[i]));
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 5;
         if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL grant[%0d] bus_ack got %b want %b", i, bus.bus_ack, e.ack); end
         if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL grant[%0d] htrans got %b want %b", i, bus.htrans, e.htr); end
         if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL grant[%0d] haddr got %h want %h", i, bus.haddr, e.haddr); end
         if (bus.hwrite !== e.hwrite) begin n_fail++; $display("FAIL grant[%0d] hwrite got %b want %b", i, bus.hwrite, e.hwrite); end
         if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL grant[%0d] hwdata got %h want %h", i, bus.hwdata, e.hwdata); end
         if (e.ack != 3'b000) begin
            n_cmp++;
            if (bus.owner !== e.owner) begin n_fail++; $display("FAIL grant[%0d] owner got %0d want %0d", i, bus.owner, e.owner); end
         end
      end
   endtask

   task automatic test_lock();
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(3'b100, I, I, I, 1'b1, 3'b100, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b101, I, I, N, 1'b1, 3'b100, N, 1'b1, 2'd2));
      rows.push_back(mk(3'b101, I, I, N, 1'b1, 3'b100, N, 1'b1, 2'd2));
      rows.push_back(mk(3'b001, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b001, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b001, I, I, I, 1'b1, 3'b001, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(expect_of(rows[i]));
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 5;
         if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL lock[%0d] bus_ack got %b want %b", i, bus.bus_ack, e.ack); end
         if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL lock[%0d] htrans got %b want %b", i, bus.htrans, e.htr); end
         if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL lock[%0d] haddr got %h want %h", i, bus.haddr, e.haddr); end
         if (bus.hwrite !== e.hwrite) begin n_fail++; $display("FAIL lock[%0d] hwrite got %b want %b", i, bus.hwrite, e.hwrite); end
         if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL lock[%0d] hwdata got %h want %h", i, bus.hwdata, e.hwdata); end
         if (e.ack != 3'b000) begin
            n_cmp++;
            if (bus.owner !== e.owner) begin n_fail++; $display("FAIL lock[%0d] owner got %0d want %0d", i, bus.owner, e.owner); end
         end
      end
   endtask

   task automatic test_data_mux();
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(3'b001, I, I, I, 1'b1, 3'b001, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b001, N, I, I, 1'b1, 3'b001, N, 1'b1, 2'd0));
      rows.push_back(mk(3'b001, I, I, I, 1'b0, 3'b001, I, 1'b1, 2'd0));
      rows.push_back(mk(3'b001, I, I, I, 1'b0, 3'b001, I, 1'b1, 2'd0));
      rows.push_back(mk(3'b001, I, I, I, 1'b1, 3'b001, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(expect_of(rows[i]));
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 5;
         if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL dmux[%0d] bus_ack got %b want %b", i, bus.bus_ack, e.ack); end
         if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL dmux[%0d] htrans got %b want %b", i, bus.htrans, e.htr); end
         if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL dmux[%0d] haddr got %h want %h", i, bus.haddr, e.haddr); end
         if (bus.hwrite !== e.hwrite) begin n_fail++; $display("FAIL dmux[%0d] hwrite got %b want %b", i, bus.hwrite, e.hwrite); end
         if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL dmux[%0d] hwdata got %h want %h", i, bus.hwdata, e.hwdata); end
         if (e.ack != 3'b000) begin
            n_cmp++;
            if (bus.owner !== e.owner) begin n_fail++; $display("FAIL dmux[%0d] owner got %0d want %0d", i, bus.owner, e.owner); end
         end
      end
   endtask

   task automatic test_late_release();
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(3'b010, I, I, I, 1'b1, 3'b010, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b010, I, N, I, 1'b1, 3'b010, N, 1'b1, 2'd1));
      rows.push_back(mk(3'b000, I, N, I, 1'b0, 3'b010, N, 1'b1, 2'd1));
      rows.push_back(mk(3'b000, I, I, I, 1'b0, 3'b010, I, 1'b1, 2'd1));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(expect_of(rows[i]));
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 5;
         if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL late[%0d] bus_ack got %b want %b", i, bus.bus_ack, e.ack); end
         if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL late[%0d] htrans got %b want %b", i, bus.htrans, e.htr); end
         if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL late[%0d] haddr got %h want %h", i, bus.haddr, e.haddr); end
         if (bus.hwrite !== e.hwrite) begin n_fail++; $display("FAIL late[%0d] hwrite got %b want %b", i, bus.hwrite, e.hwrite); end
         if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL late[%0d] hwdata got %h want %h", i, bus.hwdata, e.hwdata); end
         if (e.ack != 3'b000) begin
            n_cmp++;
            if (bus.owner !== e.owner) begin n_fail++; $display("FAIL late[%0d] owner got %0d want %0d", i, bus.owner, e.owner); end
         end
      end
   endtask

   task automatic test_priority();
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(3'b111, I, I, I, 1'b0, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b111, I, I, I, 1'b1, 3'b001, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b110, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b110, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b110, I, I, I, 1'b1, 3'b010, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b100, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b110, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b110, I, I, I, 1'b1, TIE2_ACK, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rows.push_back(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(expect_of(rows[i]));
         @(negedge clk);
         e = sb.pop_front();
         n_cmp += 5;
         if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL prio[%0d] bus_ack got %b want %b", i, bus.bus_ack, e.ack); end
         if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL prio[%0d] htrans got %b want %b", i, bus.htrans, e.htr); end
         if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL prio[%0d] haddr got %h want %h", i, bus.haddr, e.haddr); end
         if (bus.hwrite !== e.hwrite) begin n_fail++; $display("FAIL prio[%0d] hwrite got %b want %b", i, bus.hwrite, e.hwrite); end
         if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL prio[%0d] hwdata got %h want %h", i, bus.hwdata, e.hwdata); end
         if (e.ack != 3'b000) begin
            n_cmp++;
            if (bus.owner !== e.owner) begin n_fail++; $display("FAIL prio[%0d] owner got %0d want %0d", i, bus.owner, e.owner); end
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      apply(mk(3'b001, I, I, I, 1'b1, 3'b001, I, 1'b0, 2'd0));
      @(negedge clk);
      apply(mk(3'b001, N, I, I, 1'b1, 3'b001, N, 1'b1, 2'd0));
      sb.push_back(expect_of(mk(3'b001, N, I, I, 1'b1, 3'b001, N, 1'b1, 2'd0)));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL arst_pre bus_ack got %b want %b", bus.bus_ack, e.ack); end
      if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL arst_pre htrans got %b want %b", bus.htrans, e.htr); end
      if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL arst_pre hwdata got %h want %h", bus.hwdata, e.hwdata); end
      // reset lands mid-cycle, well before the next rising edge
      #2;
      rst = 1'b1;
      sb.push_back(expect_of(mk(3'b001, N, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0)));
      #1;
      e = sb.pop_front();
      n_cmp += 4;
      if (bus.bus_ack !== e.ack)   begin n_fail++; $display("FAIL arst bus_ack got %b want %b", bus.bus_ack, e.ack); end
      if (bus.htrans !== e.htr)    begin n_fail++; $display("FAIL arst htrans got %b want %b", bus.htrans, e.htr); end
      if (bus.haddr !== e.haddr)   begin n_fail++; $display("FAIL arst haddr got %h want %h", bus.haddr, e.haddr); end
      if (bus.hwdata !== e.hwdata) begin n_fail++; $display("FAIL arst hwdata got %h want %h", bus.hwdata, e.hwdata); end
      @(negedge clk);
      apply(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));
      rst = 1'b0;
      sb.push_back(expect_of(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0)));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (bus.bus_ack !== e.ack) begin n_fail++; $display("FAIL arst_post bus_ack got %b want %b", bus.bus_ack, e.ack); end
      if (bus.htrans !== e.htr)  begin n_fail++; $display("FAIL arst_post htrans got %b want %b", bus.htrans, e.htr); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      tb_addr[0]  = 64'h0000_0000_0000_1008;
      tb_addr[1]  = 64'h0000_0000_4000_2000;
      tb_addr[2]  = 64'h0000_0000_8000_1000;
      tb_wdata[0] = 64'h0000_0000_DEAD_BEEF;
      tb_wdata[1] = 64'h1111_0000_1111_0001;
      tb_wdata[2] = 64'h2222_0000_2222_0002;
      bus.m_haddr     = {tb_addr[2], tb_addr[1], tb_addr[0]};
      bus.m_hwdata    = {tb_wdata[2], tb_wdata[1], tb_wdata[0]};
      bus.m_hwrite    = tb_write;
      bus.m_hsize     = {4'd3, 4'd3, 4'd3};
      bus.m_hburst    = '0;
      bus.m_hprot     = {4'b0011, 4'b0011, 4'b0011};
      bus.m_hmastlock = '0;
      bus.hresp       = 1'b0;
      apply(mk(3'b000, I, I, I, 1'b1, 3'b000, I, 1'b0, 2'd0));

      test_reset();
      test_grant_latency();
      test_lock();
      test_data_mux();
      test_late_release();
      test_priority();
      test_async_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/biu_ahb_arbiter.md
Name: biu_ahb_arbiter

Overview:
- Shares the single AHB master port of the BIU between three requesters: 0 = TLB bus unit (page-table walk and PTE write-through), 1 = D-cache refill/writeback, 2 = I-cache refill.
- Each requester raises bus_req and drives AHB master signals only while its bus_ack is high.
- The arbiter muxes the address phase from the address-phase owner and hwdata from the data-phase owner.
- Response signals are broadcast to all requesters.

Parameters:
- NM, 3, number of requesters. Fixed at 3 for this revision; index 0 has highest priority.
- AW, 64, haddr width.
- DW, 64, hwdata/hrdata width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- bus_req  in  NM  per-requester bus request (bit i = requester i)
- bus_ack  out  NM  one-hot grant, or all zero
- m_haddr  in  NM*AW  requester i haddr at [i*AW +: AW]
- m_hwrite  in  NM  per-requester hwrite
- m_hsize  in  NM*4  per-requester hsize
- m_hburst  in  NM*3  per-requester hburst
- m_hprot  in  NM*4  per-requester hprot
- m_htrans  in  NM*2  per-requester htrans (00 = IDLE, 10 = NONSEQ)
- m_hmastlock  in  NM  per-requester hmastlock
- m_hwdata  in  NM*DW  per-requester hwdata
- haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata  out  AW/1/4/3/4/2/1/DW  muxed AHB master outputs
- hready  in  1  AHB ready
- hresp  in  1  AHB error response
- owner  out  2  current address-phase owner index; valid when bus_ack != 0

Behaviour:
- Reset (asynchronous) forces:
  - state = ARB_IDLE, bus_ack = 0, owner = 0, data_owner_vld = 0.
  - All AHB outputs 0; htrans = IDLE.
- ARB_IDLE:
  - AHB outputs held at 0 / IDLE.
  - If any bus_req is set and hready = 1, select the winner: lowest index set.
  - Register owner = winner and bus_ack = onehot(winner); go to ARB_OWN.
  - Grant is visible the cycle after bus_req is sampled, so grant latency is 1 clk.
  - If hready = 0, remain in ARB_IDLE.
- ARB_OWN:
  - haddr/hwrite/hsize/hburst/hprot/htrans/hmastlock come combinationally from m_*[owner].
  - Ownership is locked while bus_req[owner] = 1. Higher-priority requests do not preempt, so a page walk is never split.
  - Release when bus_req[owner] = 0 AND m_htrans[owner] = IDLE AND hready = 1.
  - On release: bus_ack <= 0, go to ARB_HANDOVER.
  - If bus_req[owner] drops while m_htrans[owner] = NONSEQ or hready = 0, keep the grant until both conditions hold.
- ARB_HANDOVER:
  - Lasts exactly one cycle: bus_ack = 0, htrans = IDLE; the previous owner's data phase completes here. Then go to ARB_IDLE.
  - Minimum gap between two different grants is therefore 2 idle address cycles.
- Data-phase tracking:
  - When hready = 1 and the muxed htrans = NONSEQ, register data_owner <= owner and data_owner_vld <= 1.
  - When hready = 1 and htrans = IDLE, clear data_owner_vld.
  - hwdata = m_hwdata[data_owner] if data_owner_vld, else 0.
  - While hready = 0, data_owner is held.
- hresp:
  - No arbiter action; the requester handles the error and drops its request.
  - The arbiter releases through the normal release rule.
  - Two-cycle ERROR: the second cycle carries hready = 1; no special case.
- Simultaneous events:
  - A release and new requests in the same cycle: the new winner is evaluated in ARB_IDLE, never in the release cycle.
  - If the released owner keeps bus_req low, it is excluded.
  - If it re-asserts bus_req, it competes normally.
- bus_ack is never asserted to more than one requester.
- Reset mid-transfer aborts immediately: outputs go IDLE and no data-phase completion is tracked.

Optional Feature:
- BIU_ARB_RR_EN defined:
  - Requester 0 (TLB) keeps absolute priority.
  - Requesters 1 and 2 alternate via a 1-bit last_grant register (updated on every grant to 1 or 2). When both request, the one not granted last wins.
  - last_grant resets to 2, so requester 1 wins the first tie.
- Undefined: fixed priority 0 > 1 > 2 and no last_grant register.

Test Plan:
- Grant latency: reset, then bus_req = 3'b100 at cycle 0 with hready = 1 -> bus_ack = 3'b100 at cycle 1, owner = 2; haddr = m_haddr[2] = 0x8000_1000 while htrans = 10.
- Lock: owner = 2 holding; raise bus_req[0] mid-refill -> bus_ack stays 3'b100 until req2 drops; then 1 HANDOVER cycle, then bus_ack = 3'b001 two cycles after the release.
- Data mux: owner 0 issues a write NONSEQ (haddr 0x1008, hwdata 0xDEAD_BEEF) with hready = 0 for 2 cycles -> hwdata = 0xDEAD_BEEF through every stalled data-phase cycle; hwdata = 0 once data_owner_vld clears.
- Late release: owner drops bus_req while its m_htrans = NONSEQ and hready = 0 -> bus_ack is held until hready = 1 with htrans = IDLE.
- Priority tie: bus_req = 3'b111 in ARB_IDLE -> bus_ack = 3'b001. With BIU_ARB_RR_EN and bus_req = 3'b110 twice in succession -> grants go to 1, then 2.
- Async reset asserted mid ARB_OWN with htrans = NONSEQ -> bus_ack = 0 and htrans = 00 in the same cycle, without waiting for clk.
